// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select codes, destination record, match helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipe_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EXMEM  = 2'b01;
    localparam logic [1:0] FWD_MEMWB  = 2'b10;
    localparam logic [1:0] FWD_WBHOLD = 2'b11;

    // v is set only for a real instruction that writes the register file
    typedef struct packed {
        logic       v;
        logic [4:0] dest;
        logic       m2reg;
    } rec_t;

    localparam rec_t REC_NONE = '0;

    // A used operand hits a live producer; $0 is never a producer
    function automatic logic rec_match(input rec_t rec, input logic used, input logic [4:0] r);
        return used && rec.v && (rec.dest != 5'd0) && (rec.dest == r);
    endfunction

    // Nearest producer wins; a load still in EX cannot forward its data
    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem,
                                           input logic hit_wb, input logic ex_is_load);
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit_ex && !ex_is_load) begin
            sel = FWD_EXMEM;
        end else if (hit_mem) begin
            sel = FWD_MEMWB;
        end else if (hit_wb) begin
            sel = FWD_WBHOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle between pipeline and controller.
// Latency: n/a (wires only).
// Backpressure: pc_stall/ifid_stall/idex_bubble returned to the pipeline.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [4:0]       id_dest;
    logic             ex_branch_taken;

    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg,
               id_dest, ex_branch_taken,
        input  pc_stall, ifid_stall, idex_bubble, ifid_flush, ex_fwd_a, ex_fwd_b,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg,
               id_dest, ex_branch_taken,
        output pc_stall, ifid_stall, idex_bubble, ifid_flush, ex_fwd_a, ex_fwd_b,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_dest_tracker.sv
// Shadow of the EX/MEM/WB destination records, advancing one slot per cycle.
// Latency: 1 cycle from ID record to rec_ex, then one stage per cycle.
// Backpressure: bubble_i replaces the ID record with an invalid one; never stalls itself.
module dest_tracker
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  rec_t id_rec_i,
    input  logic bubble_i,
    output rec_t rec_ex_o,
    output rec_t rec_mem_o,
    output rec_t rec_wb_o
);

    rec_t rec_ex_d;
    rec_t rec_ex_q;
    rec_t rec_mem_q;
    rec_t rec_wb_q;

    assign rec_ex_d = bubble_i ? REC_NONE : id_rec_i;

    // Records march EX -> MEM -> WB in lockstep with the real pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_ex_q  <= REC_NONE;
            rec_mem_q <= REC_NONE;
            rec_wb_q  <= REC_NONE;
        end else begin
            rec_ex_q  <= rec_ex_d;
            rec_mem_q <= rec_ex_q;
            rec_wb_q  <= rec_mem_q;
        end
    end

    assign rec_ex_o  = rec_ex_q;
    assign rec_mem_o = rec_mem_q;
    assign rec_wb_o  = rec_wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall, bubble, flush and operand-forward selects.
// Latency: stall/flush combinational in the same cycle; forward selects registered, 1 cycle.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; a taken branch flushes and wins over a stall.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FORWARD = 1,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave ctrl_if
);

    localparam logic FWD_EN = (FORWARD != 0);

    rec_t             id_rec;
    rec_t             rec_ex;
    rec_t             rec_mem;
    rec_t             rec_wb;
    logic             use_rs;
    logic             use_rt;
    logic             ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    logic             load_use;
    logic             raw_any;
    logic             stall_req;
    logic             stall;
    logic             flush;
    logic             bubble;
    logic [1:0]       fwd_a_d, fwd_a_q;
    logic [1:0]       fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic             unused_m2reg;

    // Only the EX producer's load flag matters; older loads already have their data
    assign unused_m2reg = rec_mem.m2reg ^ rec_wb.m2reg;

    assign id_rec = '{v:     ctrl_if.id_valid & ctrl_if.id_wreg,
                      dest:  ctrl_if.id_dest,
                      m2reg: ctrl_if.id_m2reg};

    dest_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .id_rec_i  (id_rec),
        .bubble_i  (bubble),
        .rec_ex_o  (rec_ex),
        .rec_mem_o (rec_mem),
        .rec_wb_o  (rec_wb)
    );

    // Match ID operands against in-flight producers and decide stall/flush
    always_comb begin
        use_rs    = ctrl_if.id_valid & ctrl_if.id_use_rs;
        use_rt    = ctrl_if.id_valid & ctrl_if.id_use_rt;
        ex_a      = rec_match(rec_ex,  use_rs, ctrl_if.id_rs);
        ex_b      = rec_match(rec_ex,  use_rt, ctrl_if.id_rt);
        mem_a     = rec_match(rec_mem, use_rs, ctrl_if.id_rs);
        mem_b     = rec_match(rec_mem, use_rt, ctrl_if.id_rt);
        wb_a      = rec_match(rec_wb,  use_rs, ctrl_if.id_rs);
        wb_b      = rec_match(rec_wb,  use_rt, ctrl_if.id_rt);
        load_use  = (ex_a | ex_b) & rec_ex.m2reg;
        raw_any   = ex_a | ex_b | mem_a | mem_b | wb_a | wb_b;
        stall_req = FWD_EN ? load_use : raw_any;
        flush     = ctrl_if.ex_branch_taken;
        // A flushed ID instruction is on the wrong path, so its stall is moot
        stall     = stall_req & ~flush;
        bubble    = stall_req | flush;
    end

    // Forward selects for the instruction about to enter EX; a bubble carries 00
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (FWD_EN && !bubble) begin
            fwd_a_d = fwd_sel(ex_a, mem_a, wb_a, rec_ex.m2reg);
            fwd_b_d = fwd_sel(ex_b, mem_b, wb_b, rec_ex.m2reg);
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Forward-select and counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctrl_if.pc_stall    = stall;
    assign ctrl_if.ifid_stall  = stall;
    assign ctrl_if.idex_bubble = bubble;
    assign ctrl_if.ifid_flush  = flush;
    assign ctrl_if.ex_fwd_a    = fwd_a_q;
    assign ctrl_if.ex_fwd_b    = fwd_b_q;
    assign ctrl_if.stall_cnt   = stall_cnt_q;
    assign ctrl_if.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: forwarding and stall-only instances driven by the same ID stream.
// Latency: checks combinational outputs mid-cycle, registered outputs one cycle later.
// Backpressure: model tracks issued slots, inserting empty slots whenever a bubble is expected.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_dest;

    // Instance 0: stall-only with 2-bit counters; instance 1: forwarding with 16-bit counters
    hazard_ctrl_if #(.CNT_W(2))  bus0 ();
    hazard_ctrl_if #(.CNT_W(16)) bus1 ();

    hazard_ctrl #(.FORWARD(0), .CNT_W(2))  u_stl (.clk(clk), .rst(rst), .ctrl_if(bus0.slave));
    hazard_ctrl #(.FORWARD(1), .CNT_W(16)) u_fwd (.clk(clk), .rst(rst), .ctrl_if(bus1.slave));

    assign bus0.id_valid = id_valid;   assign bus1.id_valid = id_valid;
    assign bus0.id_rs = id_rs;         assign bus1.id_rs = id_rs;
    assign bus0.id_rt = id_rt;         assign bus1.id_rt = id_rt;
    assign bus0.id_use_rs = id_use_rs; assign bus1.id_use_rs = id_use_rs;
    assign bus0.id_use_rt = id_use_rt; assign bus1.id_use_rt = id_use_rt;
    assign bus0.id_wreg = id_wreg;     assign bus1.id_wreg = id_wreg;
    assign bus0.id_m2reg = id_m2reg;   assign bus1.id_m2reg = id_m2reg;
    assign bus0.id_dest = id_dest;     assign bus1.id_dest = id_dest;
    assign bus0.ex_branch_taken = ex_branch_taken;
    assign bus1.ex_branch_taken = ex_branch_taken;

    logic [31:0] o_ps[2], o_is[2], o_bb[2], o_fl[2], o_fa[2], o_fb[2], o_sc[2], o_fc[2];
    assign o_ps[0] = 32'(bus0.pc_stall);    assign o_ps[1] = 32'(bus1.pc_stall);
    assign o_is[0] = 32'(bus0.ifid_stall);  assign o_is[1] = 32'(bus1.ifid_stall);
    assign o_bb[0] = 32'(bus0.idex_bubble); assign o_bb[1] = 32'(bus1.idex_bubble);
    assign o_fl[0] = 32'(bus0.ifid_flush);  assign o_fl[1] = 32'(bus1.ifid_flush);
    assign o_fa[0] = 32'(bus0.ex_fwd_a);    assign o_fa[1] = 32'(bus1.ex_fwd_a);
    assign o_fb[0] = 32'(bus0.ex_fwd_b);    assign o_fb[1] = 32'(bus1.ex_fwd_b);
    assign o_sc[0] = 32'(bus0.stall_cnt);   assign o_sc[1] = 32'(bus1.stall_cnt);
    assign o_fc[0] = 32'(bus0.flush_cnt);   assign o_fc[1] = 32'(bus1.flush_cnt);

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: for each instance, what was issued into EX 1, 2 and 3 cycles ago
    typedef struct {
        bit       wr;
        bit [4:0] dest;
        bit       ld;
    } slot_t;

    slot_t hist[2][3];
    int    exp_fa[2], exp_fb[2], exp_sc[2], exp_fc[2];
    int    cnt_max[2] = '{3, 65535};

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        n_vec++;
        assert (obs === 32'(expv)) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // How many slots back the nearest writer of r sits (1..3), 0 if none or $0
    function automatic int near(input int i, input logic used, input logic [4:0] r);
        if (!(id_valid && used) || r == 5'd0) return 0;
        for (int k = 0; k < 3; k++) begin
            if (hist[i][k].wr && hist[i][k].dest == r) return k + 1;
        end
        return 0;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) hist[i][k] = '{wr: 1'b0, dest: 5'd0, ld: 1'b0};
            exp_fa[i] = 0; exp_fb[i] = 0; exp_sc[i] = 0; exp_fc[i] = 0;
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wreg = 0; id_m2reg = 0; id_dest = 0; ex_branch_taken = 0;
    endtask

    task automatic ins(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic wr,
                       input logic ld, input logic [4:0] dst, input logic br);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_wreg = wr; id_m2reg = ld; id_dest = dst; ex_branch_taken = br;
    endtask

    // One clock: compare both instances against the model, then advance the model
    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int da, db;
            bit stl, fl, bub;
            da = near(i, id_use_rs, id_rs);
            db = near(i, id_use_rt, id_rt);
            if (i == 1) stl = ((da == 1) || (db == 1)) && hist[i][0].ld;
            else        stl = (da != 0) || (db != 0);
            fl  = ex_branch_taken;
            bub = stl || fl;
            chk($sformatf("ex_fwd_a[%0d]", i), o_fa[i], exp_fa[i]);
            chk($sformatf("ex_fwd_b[%0d]", i), o_fb[i], exp_fb[i]);
            chk($sformatf("stall_cnt[%0d]", i), o_sc[i], exp_sc[i]);
            chk($sformatf("flush_cnt[%0d]", i), o_fc[i], exp_fc[i]);
            chk($sformatf("pc_stall[%0d]", i), o_ps[i], int'(stl && !fl));
            chk($sformatf("ifid_stall[%0d]", i), o_is[i], int'(stl && !fl));
            chk($sformatf("idex_bubble[%0d]", i), o_bb[i], int'(bub));
            chk($sformatf("ifid_flush[%0d]", i), o_fl[i], int'(fl));
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = '{wr: !bub && id_valid && id_wreg, dest: id_dest, ld: id_m2reg};
            // Select code equals the producer distance: 1=EX/MEM, 2=MEM/WB, 3=WB hold
            exp_fa[i] = (bub || i == 0) ? 0 : da;
            exp_fb[i] = (bub || i == 0) ? 0 : db;
            if (stl && !fl && exp_sc[i] < cnt_max[i]) exp_sc[i]++;
            if (fl && exp_fc[i] < cnt_max[i]) exp_fc[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        idle();
        repeat (n) cyc();
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_pc_stall[%0d]", tag, i), o_ps[i], 0);
            chk($sformatf("%s_ifid_stall[%0d]", tag, i), o_is[i], 0);
            chk($sformatf("%s_bubble[%0d]", tag, i), o_bb[i], 0);
            chk($sformatf("%s_flush[%0d]", tag, i), o_fl[i], 0);
            chk($sformatf("%s_fwd_a[%0d]", tag, i), o_fa[i], 0);
            chk($sformatf("%s_fwd_b[%0d]", tag, i), o_fb[i], 0);
            chk($sformatf("%s_stall_cnt[%0d]", tag, i), o_sc[i], 0);
            chk($sformatf("%s_flush_cnt[%0d]", tag, i), o_fc[i], 0);
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        chk_zero("rst");
        mreset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // lw $2 then add $3,$2,$4: one load-use stall, then MEM/WB forward
        ins(1, 5'd1, 1, 5'd2, 0, 1, 1, 5'd2, 0); cyc();
        ins(1, 5'd2, 1, 5'd4, 1, 1, 0, 5'd3, 0); #2;
        chk("lu_pc_stall", o_ps[1], 1);
        chk("lu_ifid_stall", o_is[1], 1);
        chk("lu_bubble", o_bb[1], 1);
        cyc(); #2;
        chk("lu_released", o_ps[1], 0);
        cyc();
        chk("lu_fwd_a", o_fa[1], 2);
        chk("lu_fwd_b", o_fb[1], 0);
        chk("lu_stall_cnt", o_sc[1], 1);

        // add $2 then sub $5,$2,$2: EX/MEM forward on both operands
        nops(3);
        ins(1, 5'd1, 1, 5'd1, 1, 1, 0, 5'd2, 0); cyc();
        ins(1, 5'd2, 1, 5'd2, 1, 1, 0, 5'd5, 0); #2;
        chk("alu_no_stall", o_ps[1], 0);
        cyc();
        chk("alu_fwd_a", o_fa[1], 1);
        chk("alu_fwd_b", o_fb[1], 1);

        // add $2, nop, nop, or $6,$2,$0: WB-hold forward, $0 never forwards
        nops(3);
        ins(1, 5'd1, 1, 5'd1, 1, 1, 0, 5'd2, 0); cyc();
        nops(2);
        ins(1, 5'd2, 1, 5'd0, 1, 1, 0, 5'd6, 0); cyc();
        chk("wb_fwd_a", o_fa[1], 3);
        chk("wb_fwd_b_r0", o_fb[1], 0);

        // Writer of $0 then reader of $0: no hazard on either instance
        nops(3);
        ins(1, 5'd1, 1, 5'd1, 1, 1, 0, 5'd0, 0); cyc();
        ins(1, 5'd0, 1, 5'd0, 1, 1, 0, 5'd7, 0); #2;
        chk("r0_no_stall_fwd", o_ps[1], 0);
        chk("r0_no_stall_stl", o_ps[0], 0);
        cyc();
        chk("r0_fwd_a", o_fa[1], 0);
        chk("r0_fwd_b", o_fb[1], 0);

        // Taken branch with a simultaneous load-use: flush wins
        do_reset();
        ins(1, 5'd1, 1, 5'd2, 0, 1, 1, 5'd2, 0); cyc();
        ins(1, 5'd2, 1, 5'd4, 1, 1, 0, 5'd3, 1); #2;
        chk("br_flush", o_fl[1], 1);
        chk("br_pc_stall", o_ps[1], 0);
        chk("br_ifid_stall", o_is[1], 0);
        chk("br_bubble", o_bb[1], 1);
        cyc();
        chk("br_flush_cnt", o_fc[1], 1);
        chk("br_stall_cnt", o_sc[1], 0);

        // Randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            id_valid        = ($urandom_range(9) < 8);
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            id_use_rs       = 1'($urandom);
            id_use_rt       = 1'($urandom);
            id_wreg         = ($urandom_range(9) < 7);
            id_m2reg        = ($urandom_range(9) < 3);
            id_dest         = 5'($urandom_range(3));
            ex_branch_taken = ($urandom_range(9) == 0);
            cyc();
        end

        // Stall-only instance: back-to-back dependency costs exactly 3 stalls
        do_reset();
        ins(1, 5'd1, 1, 5'd1, 1, 1, 0, 5'd2, 0); cyc();
        for (int k = 0; k < 4; k++) begin
            ins(1, 5'd2, 1, 5'd2, 1, 1, 0, 5'd3, 0); #2;
            chk($sformatf("nf_stall_%0d", k), o_ps[0], int'(k < 3));
            cyc();
        end
        chk("nf_stall_cnt_full", o_sc[0], 3);

        // Counter already all-ones: one more stall leaves it saturated
        ins(1, 5'd1, 1, 5'd1, 1, 1, 0, 5'd2, 0); cyc();
        ins(1, 5'd2, 1, 5'd2, 1, 1, 0, 5'd3, 0); #2;
        chk("sat_stalling", o_ps[0], 1);
        cyc();
        chk("sat_stall_cnt", o_sc[0], 3);

        // Reset asserted mid-stall drops every output at once
        ins(1, 5'd2, 1, 5'd2, 1, 1, 0, 5'd3, 0); #2;
        chk("mid_stalling", o_ps[0], 1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage and keeps a shadow pipeline of in-flight destination records for EX, MEM and WB. From these records it decides, each cycle, whether to stall IF/ID, insert an EX bubble, or flush on a taken branch. It also produces registered operand-forwarding selects that the EX stage uses on the following cycle.

## Interface
Parameters:
- FORWARD, default 1: 1 enables forwarding; 0 resolves every RAW hazard by stalling.
- CNT_W, default 16: width of the stall and flush performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  5  source register fields (inst[25:21], inst[20:16]).
- id_use_rs, id_use_rt  in  1  the instruction actually reads rs / rt.
- id_wreg  in  1  the instruction writes the register file (cu_wreg).
- id_m2reg  in  1  the instruction is a load (cu_m2reg).
- id_dest  in  5  destination register (rt or rd, already selected by cu_regrt).
- ex_branch_taken  in  1  the branch in EX resolved taken this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold the IF/ID register.
- idex_bubble  out  1  load a NOP (all write enables 0) into ID/EX.
- ifid_flush  out  1  load a NOP into IF/ID.
- ex_fwd_a, ex_fwd_b  out  2  registered operand selects for the instruction now in EX.
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

## Operation
- Record fields: v, dest, m2reg. A record is live only when v=1 and id_wreg=1 and dest!=0. Register $0 never causes a hazard and is never a forwarding source.
- Shadow pipeline: rec_ex, rec_mem, rec_wb. Every cycle rec_wb<=rec_mem and rec_mem<=rec_ex. rec_ex<=ID record, or an invalid record when idex_bubble=1.
- match_X(r): the operand is used AND rec_X is live AND rec_X.dest==r.
- FORWARD=1:
  - load_use = match_ex(rs or rt) && rec_ex.m2reg. This is a stall.
  - Forward codes, per operand, evaluated in ID and registered into ex_fwd_*. Priority is 01 > 10 > 11 > 00.
  - 01 = EX/MEM ALU result, chosen when match_ex and not a load.
  - 10 = MEM/WB result, chosen when match_mem.
  - 11 = WB value held one cycle by the datapath, chosen when match_wb. This covers the regfile write landing on the same edge as the ID/EX capture.
  - 00 = regfile.
- FORWARD=0: stall when any of match_ex, match_mem or match_wb is true. ex_fwd_* is always 00.
- Stall: pc_stall = ifid_stall = idex_bubble = 1.
- Flush (ex_branch_taken=1): ifid_flush = idex_bubble = 1; pc_stall = ifid_stall = 0. Flush overrides a simultaneous stall, because the stalled instruction is on the wrong path.
- When id_valid=0, no stall is raised and the record is invalid.
- When a stall or flush occurs, the registered ex_fwd_* loaded with the bubble is 00.
- Counters: stall_cnt increments once per stall cycle and flush_cnt once per flush cycle. Both saturate at all-ones; no wrap.

## Timing
- Reset (asynchronous): all records invalid, ex_fwd_a/b=00, counters 0. Combinational outputs are therefore 0 while rst=1 and on the first cycle after reset.
- Stall and flush outputs are combinational from the current records and ID inputs, valid within the same cycle.
- Forward selects have 1-cycle latency. The code computed while the instruction is in ID appears on ex_fwd_* in the cycle that instruction occupies EX.
- Load-use costs exactly 1 stall cycle. On the next cycle the load is in MEM and the dependent instruction receives 10.
- FORWARD=0 back-to-back dependency costs 3 stall cycles.
- Taken branch costs 2 squashed slots: IF/ID and ID/EX.
- If reset is asserted mid-stall, the stall drops immediately and no partial counter update occurs.

## Structure
- Shared package pipe_pkg:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WBHOLD=2'b11.
  - Record typedef {v, dest[4:0], m2reg}.
  - Hazard check function usable by both RTL and bench.
- One sub-module, dest_tracker: the 3-deep record shift register with bubble insert, exposing rec_ex, rec_mem and rec_wb.

## Test plan
- lw $2 followed by add $3,$2,$4 -> one cycle with pc_stall=ifid_stall=idex_bubble=1, then add in EX with ex_fwd_a=10; stall_cnt=1.
- add $2, then sub $5,$2,$2 -> no stall; ex_fwd_a=ex_fwd_b=01.
- add $2, nop, nop, or $6,$2,$0 -> ex_fwd_a=11, ex_fwd_b=00 ($0 never forwards).
- Writer to $0, then reader of $0 -> no stall, fwd 00.
- ex_branch_taken=1 in the same cycle as a load-use condition -> ifid_flush=1, pc_stall=0, flush_cnt +1, stall_cnt unchanged.
- FORWARD=0: add $2 then add $3,$2,$2 -> exactly 3 stall cycles. Then force stall_cnt to all-ones and stall once more -> counter stays all-ones. Assert rst mid-stall -> all outputs 0 immediately.
